bsg_fifo_rate_bridge: RTL and testbench

Single-clock, rate-adapting FIFO bridge between two handshake ports that each act only on their own periodic phase tick, derived from internal phase counters. It generalises the control-only periodic divider: it carries a payload of width_p bits, buffers els_p entries, and accepts arbitrary integer A-side and B-side periods. It sits between full-rate logic and a block that is strobe-enabled at 1/b_period_p rate, such as a cache behind a divided clock, in either direction.

---
 rtl/bsg_fifo_rate_bridge_pkg.sv | 18 +
 rtl/bsg_fifo_rate_bridge_phase_ctr.sv | 38 +++
 rtl/bsg_fifo_rate_bridge.sv | 133 +++++++++++++
 tb/tb_bsg_fifo_rate_bridge.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/bsg_fifo_rate_bridge_pkg.sv
// Shared sizing helpers for the rate-adapting FIFO bridge.
package bsg_fifo_rate_bridge_pkg;

   // Bits needed to index n entries, never less than one.
   function automatic int safe_clog2(input int n);
      if (n <= 1) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

   // Bits needed to hold the value n itself.
   function automatic int width_of(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/bsg_fifo_rate_bridge_phase_ctr.sv
// Free-running phase counter; tick_o is high whenever the phase is zero.
module bsg_fifo_rate_phase_ctr
   import bsg_fifo_rate_bridge_pkg::*;
#(
   parameter int period_p = 1
)(
   input  logic clk_i,
   input  logic reset_i,
   output logic tick_o
);

   localparam int pw_lp = safe_clog2(period_p);
   localparam logic [pw_lp-1:0] last_lp = pw_lp'(period_p - 1);

   logic [pw_lp-1:0] ph_q, ph_d;

   // wrap explicitly at period-1 so any integer period works
   always_comb begin
      ph_d = ph_q;
      if (ph_q == last_lp) begin
         ph_d = '0;
      end else begin
         ph_d = ph_q + pw_lp'(1);
      end
   end

   // phase register
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ph_q <= '0;
      end else begin
         ph_q <= ph_d;
      end
   end

   assign tick_o = (ph_q == '0);

endmodule

// File: rtl/bsg_fifo_rate_bridge.sv
// Single-clock FIFO bridging an A-tick write port to a B-tick read port.
// Define BSG_FIFO_RATE_BRIDGE_BYPASS_EN to let a push load an idle output register directly.
module bsg_fifo_rate_bridge
   import bsg_fifo_rate_bridge_pkg::*;
#(
   parameter int width_p    = 32,
   parameter int els_p      = 4,
   parameter int a_period_p = 1,
   parameter int b_period_p = 2
)(
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [width_p-1:0] a_data_i,
   input  logic               a_v_i,
   output logic               a_ready_and_o,
   output logic               a_tick_o,
   output logic [width_p-1:0] b_data_o,
   output logic               b_v_o,
   input  logic               b_ready_and_i,
   output logic               b_tick_o
);

   localparam int ring_els_lp = els_p - 1;
   localparam int ptr_w_lp    = safe_clog2(ring_els_lp);
   localparam int cnt_w_lp    = width_of(els_p);
   localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(ring_els_lp - 1);
   localparam logic [cnt_w_lp-1:0] els_lp      = cnt_w_lp'(els_p);
   localparam logic [cnt_w_lp-1:0] els_m1_lp   = cnt_w_lp'(els_p - 1);

   logic [width_p-1:0]  mem_q [ring_els_lp];
   logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [cnt_w_lp-1:0] count_q, count_d;
   logic                out_v_q, out_v_d, a_ready_q, a_ready_d;
   logic [width_p-1:0]  out_data_q, out_data_d;
   logic                a_tick, b_tick, push, pop, load, bypass, ring_empty, ring_wr;

   function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
      if (p == last_ptr_lp) begin
         return '0;
      end else begin
         return p + ptr_w_lp'(1);
      end
   endfunction

   bsg_fifo_rate_phase_ctr #(.period_p(a_period_p)) a_ctr (
      .clk_i(clk_i), .reset_i(reset_i), .tick_o(a_tick));
   bsg_fifo_rate_phase_ctr #(.period_p(b_period_p)) b_ctr (
      .clk_i(clk_i), .reset_i(reset_i), .tick_o(b_tick));

   // handshake decode, occupancy and output-register next state
   always_comb begin
      push       = a_tick & a_v_i & a_ready_q;
      pop        = b_tick & out_v_q & b_ready_and_i;
      load       = b_tick & (pop | ~out_v_q);
      ring_empty = (count_q == {{(cnt_w_lp-1){1'b0}}, out_v_q});
`ifdef BSG_FIFO_RATE_BRIDGE_BYPASS_EN
      bypass     = push & load & ring_empty;
`else
      bypass     = 1'b0;
`endif
      ring_wr    = push & ~bypass;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      out_v_d    = out_v_q;
      out_data_d = out_data_q;
      a_ready_d  = a_ready_q;

      case ({push, pop})
         2'b10:   count_d = count_q + cnt_w_lp'(1);
         2'b01:   count_d = count_q - cnt_w_lp'(1);
         default: count_d = count_q;
      endcase

      if (ring_wr) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (load && !ring_empty) begin
         out_v_d    = 1'b1;
         out_data_d = mem_q[rd_ptr_q];
         rd_ptr_d   = ptr_inc(rd_ptr_q);
      end else if (load && bypass) begin
         out_v_d    = 1'b1;
         out_data_d = a_data_i;
      end else if (load) begin
         out_v_d    = 1'b0;
      end else begin
         out_v_d    = out_v_q;
      end

      // the ring alone holds els_p-1, so a full ring behind an empty output register is also full
      if (a_tick) begin
         a_ready_d = (count_d < els_lp) && !(!out_v_d && (count_d == els_m1_lp));
      end else begin
         a_ready_d = a_ready_q;
      end
   end

   // control and output registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         out_v_q    <= 1'b0;
         out_data_q <= '0;
         a_ready_q  <= 1'b1;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         out_v_q    <= out_v_d;
         out_data_q <= out_data_d;
         a_ready_q  <= a_ready_d;
      end
   end

   // ring storage, contents need no reset
   always_ff @(posedge clk_i) begin
      if (ring_wr) begin
         mem_q[wr_ptr_q] <= a_data_i;
      end
   end

   assign a_ready_and_o = a_ready_q;
   assign a_tick_o      = a_tick;
   assign b_v_o         = out_v_q;
   assign b_data_o      = out_data_q;
   assign b_tick_o      = b_tick;

endmodule

// File: tb/tb_bsg_fifo_rate_bridge.sv
// Scoreboard bench: queue-based reference model for a 1:2 instance plus a 3:1 streaming instance.
module tb_bsg_fifo_rate_bridge;

   localparam int W = 32;
   localparam int ELS = 4, AP = 1, BP = 2;
   localparam int ELS1 = 3, AP1 = 3, BP1 = 1;
`ifdef BSG_FIFO_RATE_BRIDGE_BYPASS_EN
   localparam bit BYP = 1'b1;
   localparam int LAT = 1;
`else
   localparam bit BYP = 1'b0;
   localparam int LAT = 3;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [W-1:0] a_data = '0, b_data;
   logic a_v = 1'b0, a_ready, a_tick, b_v, b_ready = 1'b0, b_tick;
   logic [W-1:0] a_data1 = '0, b_data1;
   logic a_v1 = 1'b0, a_ready1, a_tick1, b_v1, b_ready1 = 1'b1, b_tick1;

   bsg_fifo_rate_bridge #(.width_p(W), .els_p(ELS), .a_period_p(AP), .b_period_p(BP)) dut (
      .clk_i(clk), .reset_i(rst), .a_data_i(a_data), .a_v_i(a_v), .a_ready_and_o(a_ready),
      .a_tick_o(a_tick), .b_data_o(b_data), .b_v_o(b_v), .b_ready_and_i(b_ready), .b_tick_o(b_tick));

   bsg_fifo_rate_bridge #(.width_p(W), .els_p(ELS1), .a_period_p(AP1), .b_period_p(BP1)) dut1 (
      .clk_i(clk), .reset_i(rst), .a_data_i(a_data1), .a_v_i(a_v1), .a_ready_and_o(a_ready1),
      .a_tick_o(a_tick1), .b_data_o(b_data1), .b_v_o(b_v1), .b_ready_and_i(b_ready1), .b_tick_o(b_tick1));

   int vectors = 0, miscompares = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model state
   int cyc_m = 0;
   bit ready_m = 1'b1, out_v_m = 1'b0;
   logic [W-1:0] out_data_m = '0;
   logic [W-1:0] ring_m[$], exp_q[$], popped_log[$];

   initial begin : model
      bit a_t, b_t, push, pop, byp;
      forever begin
         @(posedge clk);
         if (rst) begin
            cyc_m = 0; ready_m = 1'b1; out_v_m = 1'b0; out_data_m = '0;
            ring_m.delete(); exp_q.delete();
         end else begin
            a_t  = (cyc_m % AP) == 0;
            b_t  = (cyc_m % BP) == 0;
            push = a_t && a_v && ready_m;
            pop  = b_t && out_v_m && b_ready;
            byp  = 1'b0;
            if (b_t && (pop || !out_v_m)) begin
               if (ring_m.size() > 0) begin
                  out_data_m = ring_m.pop_front(); out_v_m = 1'b1;
               end else if (BYP && push) begin
                  out_data_m = a_data; out_v_m = 1'b1; byp = 1'b1;
               end else begin
                  out_v_m = 1'b0;
               end
            end
            if (push) begin
               exp_q.push_back(a_data);
               if (!byp) ring_m.push_back(a_data);
            end
            if (a_t) ready_m = (ring_m.size() + int'(out_v_m)) < ELS;
            cyc_m++;
         end
      end
   end

   initial begin : monitor
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("a_tick", a_tick, (cyc_m % AP) == 0);
            check("b_tick", b_tick, (cyc_m % BP) == 0);
            check("b_v", b_v, out_v_m);
            check("a_ready", a_ready, ready_m);
            if (out_v_m) check("b_data", b_data, out_data_m);
            if (!rst && b_v && b_tick && b_ready) begin
               if (exp_q.size() == 0) begin
                  vectors++; miscompares++;
                  $display("FAIL sb_empty: got pop of %0h expected no output", b_data);
               end else begin
                  e = exp_q.pop_front();
                  check("sb_data", b_data, e);
               end
               popped_log.push_back(b_data);
            end
         end
      end
   end

   // 3:1 instance: stream 10 words, expect order and 3-cycle pulse spacing
   int u1_cyc = 0, n1 = 0, last1 = 0;
   bit u1_run = 1'b0;

   initial begin : u1_drive
      wait (chk_en == 1'b1);
      u1_run = 1'b1;
      for (int c = 0; c < 45; c++) begin
         u1_cyc = c;
         if (c % 3 == 0) begin
            a_v1 = (c / 3) < 10; a_data1 = 100 + c / 3;
         end else begin
            a_v1 = 1'($urandom_range(0, 1)); a_data1 = $urandom;
         end
         @(posedge clk); #1;
      end
      a_v1 = 1'b0;
      u1_run = 1'b0;
   end

   initial begin : u1_mon
      forever begin
         @(negedge clk);
         if (u1_run) begin
            check("u1_a_tick", a_tick1, (u1_cyc % 3) == 0);
            if (b_v1 && b_tick1) begin
               check("u1_data", b_data1, 100 + n1);
               if (n1 > 0) check("u1_spacing", u1_cyc - last1, 3);
               last1 = u1_cyc;
               n1++;
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin : driver
      int first;
      bit hit;
      repeat (2) @(posedge clk);
      #1 chk_en = 1'b1;

      // basic transfer and latency
      rst = 1'b0; a_v = 1'b1; a_data = 32'h0000_00A5; b_ready = 1'b0;
      @(posedge clk); #1 a_v = 1'b0; b_ready = 1'b1;
      first = -1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (b_v && first < 0) first = c;
      end
      check("latency", first, LAT);
      repeat (3) @(posedge clk);
      #1 popped_log.delete();

      // fill: five pushes, four accepted
      b_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         a_v = 1'b1; a_data = k;
         @(posedge clk); #1;
      end
      a_v = 1'b0;
      @(negedge clk);
      check("fill_ready", a_ready, 1'b0);
      @(posedge clk); #1 b_ready = 1'b1;
      repeat (12) @(posedge clk);
      #1 check("fill_n", popped_log.size(), 4);
      for (int i = 0; i < popped_log.size() && i < 4; i++) check("fill_order", popped_log[i], i + 1);

      // random traffic, alternating fast and slow drain
      for (int i = 0; i < 600; i++) begin
         a_v = 1'($urandom_range(0, 1));
         a_data = $urandom;
         b_ready = ((i / 100) % 2 == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
         @(posedge clk); #1;
      end

      // drain, refill to three entries, then reset mid-operation
      a_v = 1'b0; b_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1 b_ready = 1'b0; a_v = 1'b1;
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
         a_data = $urandom;
         @(posedge clk); #1;
         hit = (ring_m.size() + int'(out_v_m)) == 3;
      end
      a_v = 1'b0;
      check("count3_reached", hit, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("rst_b_v", b_v, 1'b0);
      check("rst_a_ready", a_ready, 1'b1);
      check("rst_a_tick", a_tick, 1'b1);
      check("rst_b_tick", b_tick, 1'b1);

      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         a_v = 1'($urandom_range(0, 1)); a_data = $urandom; b_ready = 1'($urandom_range(0, 1));
      end
      a_v = 1'b0; b_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1 check("sb_drained", exp_q.size(), 0);
      check("u1_count", n1, 10);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
